// File: rtl/amo_pkg.sv
// Shared types for the data-side atomic memory bridge.
// Op codes, FSM states and line lane helpers.
package amo_pkg;

    localparam int LINE_W = 128;
    localparam int WORD_W = 32;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'd0,
        OP_STORE = 4'd1,
        OP_LR    = 4'd2,
        OP_SC    = 4'd3,
        OP_SWAP  = 4'd4,
        OP_ADD   = 4'd5,
        OP_XOR   = 4'd6,
        OP_AND   = 4'd7,
        OP_OR    = 4'd8,
        OP_MIN   = 4'd9,
        OP_MAX   = 4'd10,
        OP_MINU  = 4'd11,
        OP_MAXU  = 4'd12
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_RESP    = 3'd4
    } state_e;

    function automatic logic is_amo(logic [3:0] op);
        return (op >= OP_SWAP) && (op <= OP_MAXU);
    endfunction

    function automatic logic [LINE_W-1:0] lane_put(
        logic [1:0]        lane,
        logic [WORD_W-1:0] w
    );
        logic [LINE_W-1:0] l;
        l = '0;
        l[lane*WORD_W +: WORD_W] = w;
        return l;
    endfunction

    function automatic logic [LINE_W/8-1:0] lane_mask(
        logic [1:0] lane,
        logic [3:0] strb
    );
        logic [LINE_W/8-1:0] m;
        m = '0;
        m[lane*4 +: 4] = strb;
        return m;
    endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO*.W function: new = f(op, old, rs2).
// SWAP and any non-AMO code pass rs2 through.
module amo_alu
    import amo_pkg::*;
(
    input  logic [3:0]        i_op,
    input  logic [WORD_W-1:0] i_old,
    input  logic [WORD_W-1:0] i_rs2,
    output logic [WORD_W-1:0] o_new
);

    logic w_slt;
    logic w_ult;

    assign w_slt = $signed(i_old) < $signed(i_rs2);
    assign w_ult = i_old < i_rs2;

    always_comb begin
        o_new = i_rs2;
        case (i_op)
            OP_ADD:  o_new = i_old + i_rs2;
            OP_XOR:  o_new = i_old ^ i_rs2;
            OP_AND:  o_new = i_old & i_rs2;
            OP_OR:   o_new = i_old | i_rs2;
            OP_MIN:  o_new = w_slt ? i_old : i_rs2;
            OP_MAX:  o_new = w_slt ? i_rs2 : i_old;
            OP_MINU: o_new = w_ult ? i_old : i_rs2;
            OP_MAXU: o_new = w_ult ? i_rs2 : i_old;
            default: o_new = i_rs2;
        endcase
    end

endmodule

// File: rtl/amo_mem_bridge.sv
// CPU word port to 128-bit line RAM bridge with atomic RMW
// sequencing and the single LR/SC reservation.
module amo_mem_bridge
    import amo_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          LINE_AW   = 12
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               cpu_req_valid,
    output logic               cpu_req_ready,
    input  logic [3:0]         cpu_op,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    input  logic [3:0]         cpu_wstrb,
    output logic               cpu_resp_valid,
    output logic [31:0]        cpu_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [LINE_AW-1:0] mem_addr,
    output logic [127:0]       mem_wdata,
    output logic [15:0]        mem_wmask,
    input  logic               mem_ready,
    input  logic               mem_rvalid,
    input  logic [127:0]       mem_rdata
);

    state_e               r_state;
    op_e                  r_op;
    logic [29:0]          r_waddr;
    logic [31:0]          r_wdata;
    logic                 r_resv_vld;
    logic [29:0]          r_resv_addr;
    logic                 r_ready;
    logic                 r_resp;
    logic [31:0]          r_rdata;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [LINE_AW-1:0]   r_mem_addr;
    logic [127:0]         r_mem_wdata;
    logic [15:0]          r_mem_wmask;

    op_e                  w_cop;
    logic [LINE_AW-1:0]   w_line;
    logic                 w_hit;
    logic [1:0]           w_lane;
    logic [WORD_W-1:0]    w_old;
    logic [WORD_W-1:0]    w_alu;
    logic [WORD_W-1:0]    w_new;

    assign w_cop  = op_e'(cpu_op);
    // Out-of-window addresses simply wrap into the RAM.
    assign w_line = LINE_AW'((cpu_addr - BASE_ADDR) >> 4);
    assign w_hit  = r_resv_vld && (r_resv_addr == cpu_addr[31:2]);
    assign w_lane = r_waddr[1:0];
    assign w_old  = mem_rdata[w_lane*WORD_W +: WORD_W];
    assign w_new  = (r_op == OP_SC) ? r_wdata : w_alu;

    amo_alu u_alu (
        .i_op  (r_op),
        .i_old (w_old),
        .i_rs2 (r_wdata),
        .o_new (w_alu)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LOAD;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_resv_vld  <= 1'b0;
            r_resv_addr <= '0;
            r_ready     <= 1'b1;
            r_resp      <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req_valid) begin
                        r_ready    <= 1'b0;
                        r_op       <= w_cop;
                        r_waddr    <= cpu_addr[31:2];
                        r_wdata    <= cpu_wdata;
                        r_mem_addr <= w_line;
                        if (w_cop == OP_SC ||
                            (w_hit && (w_cop == OP_STORE ||
                                       is_amo(cpu_op))))
                            r_resv_vld <= 1'b0;
                        if (w_cop == OP_STORE) begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= lane_put(cpu_addr[3:2],
                                                    cpu_wdata);
                            r_mem_wmask <= lane_mask(cpu_addr[3:2],
                                                     cpu_wstrb);
                            r_state     <= S_WR;
                        end else if (w_cop == OP_SC && !w_hit) begin
                            r_rdata <= 32'd1;
                            r_resp  <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_mem_req <= 1'b1;
                            r_mem_we  <= 1'b0;
                            r_state   <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid) begin
                        if (is_amo(r_op) || r_op == OP_SC) begin
                            r_rdata     <= (r_op == OP_SC) ? '0 : w_old;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= lane_put(w_lane, w_new);
                            r_mem_wmask <= lane_mask(w_lane, 4'hF);
                            r_state     <= S_WR;
                        end else begin
                            r_rdata <= w_old;
                            r_resp  <= 1'b1;
                            r_state <= S_RESP;
                            if (r_op == OP_LR) begin
                                r_resv_vld  <= 1'b1;
                                r_resv_addr <= r_waddr;
                            end
                        end
                    end
                end
                S_WR: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_resp    <= 1'b1;
                        r_state   <= S_RESP;
                        if (r_op == OP_STORE)
                            r_rdata <= '0;
                    end
                end
                S_RESP: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_req_ready  = r_ready;
    assign cpu_resp_valid = r_resp;
    assign cpu_rdata      = r_rdata;
    assign mem_req        = r_mem_req;
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign mem_wmask      = r_mem_wmask;

endmodule

// File: tb/tb_amo_mem_bridge.sv
// Bench for amo_mem_bridge: line RAM responder plus a word-level
// reference model of memory and the LR/SC reservation.
module tb_amo_mem_bridge;
    import amo_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         cpu_req_valid = 1'b0;
    logic         cpu_req_ready;
    logic [3:0]   cpu_op = 4'd0;
    logic [31:0]  cpu_addr = 32'd0;
    logic [31:0]  cpu_wdata = 32'd0;
    logic [3:0]   cpu_wstrb = 4'd0;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [11:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [15:0]  mem_wmask;
    logic         mem_ready = 1'b1;
    logic         mem_rvalid = 1'b0;
    logic [127:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;

    logic [127:0] ram [0:4095];
    bit           ram_init = 1'b0;
    int           req_cnt = 0;
    int           stall_cnt = 0;
    bit           rand_stall = 1'b0;
    bit           hold_wr = 1'b0;

    logic [31:0]  mw [0:16383];
    bit           rv = 1'b0;
    logic [29:0]  ra = '0;

    always #5 CLK = ~CLK;

    amo_mem_bridge #(.BASE_ADDR(BASE), .LINE_AW(12)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_op(cpu_op), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(int j);
        return (32'(j) * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'(((a - BASE) >> 2) & 32'h3FFF);
    endfunction

    function automatic logic [31:0] ram_word(int j);
        logic [127:0] l;
        l = ram[j >> 2];
        return l[(j & 3)*32 +: 32];
    endfunction

    // RAM: accepts on mem_req && mem_ready, read data one cycle later.
    always @(posedge CLK) begin
        if (!ram_init) begin
            for (int i = 0; i < 4096; i++)
                for (int w = 0; w < 4; w++)
                    ram[i][w*32 +: 32] = init_word(i*4 + w);
            ram_init = 1'b1;
        end
        mem_rvalid <= 1'b0;
        if (mem_req) req_cnt++;
        if (mem_req && !mem_ready) stall_cnt++;
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                for (int b = 0; b < 16; b++)
                    if (mem_wmask[b])
                        ram[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
            end else begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= ram[mem_addr];
            end
        end
    end

    always @(negedge CLK) begin
        if (hold_wr && mem_we) mem_ready = 1'b0;
        else if (rand_stall) mem_ready = ($urandom_range(0, 2) != 0);
        else mem_ready = 1'b1;
    end

    function automatic logic [31:0] amo_ref(logic [3:0] op,
                                           logic [31:0] a,
                                           logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_XOR:  return a ^ b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_MIN:  return ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:  return ($signed(a) > $signed(b)) ? a : b;
            OP_MINU: return (a < b) ? a : b;
            OP_MAXU: return (a > b) ? a : b;
            default: return b;
        endcase
    endfunction

    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st,
                         output logic [31:0] rd, output int lat);
        int j;
        logic [31:0] old;
        bit hit;
        j = widx(a);
        old = mw[j];
        hit = rv && (ra == a[31:2]);
        case (op)
            OP_LOAD: begin rd = old; lat = 4; end
            OP_LR: begin rd = old; lat = 4; rv = 1'b1; ra = a[31:2]; end
            OP_STORE: begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) mw[j][b*8 +: 8] = wd[b*8 +: 8];
                if (hit) rv = 1'b0;
                rd = 32'd0; lat = 3;
            end
            OP_SC: begin
                if (hit) begin mw[j] = wd; rd = 32'd0; lat = 5; end
                else begin rd = 32'd1; lat = 2; end
                rv = 1'b0;
            end
            default: begin
                mw[j] = amo_ref(op, old, wd);
                rd = old; lat = 5;
                if (hit) rv = 1'b0;
            end
        endcase
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st,
                         output logic [31:0] rd, output int lat,
                         output int stalls);
        int n;
        int s0;
        @(negedge CLK);
        n = 0;
        while (!cpu_req_ready && n < 50) begin @(negedge CLK); n++; end
        cpu_req_valid = 1'b1;
        cpu_op = op; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = st;
        s0 = stall_cnt;
        @(posedge CLK); #1;
        cpu_req_valid = 1'b0;
        n = 0;
        while (!cpu_resp_valid && n < 200) begin
            @(posedge CLK); #1; n++;
        end
        rd = cpu_rdata;
        lat = (n >= 200) ? -1 : n + 2;
        stalls = stall_cnt - s0;
    endtask

    task automatic exec(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output int lat,
                        output logic [31:0] erd, output int elat);
        int stalls;
        do_op(op, a, wd, st, rd, lat, stalls);
        model(op, a, wd, st, erd, elat);
        elat = elat + stalls;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if ({cpu_req_ready, cpu_resp_valid, cpu_rdata} !== {1'b1, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL reset_cpu: got %b %b %h want 1 0 0",
                     cpu_req_ready, cpu_resp_valid, cpu_rdata);
        end
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== '0) begin
            bad++;
            $display("FAIL reset_mem: got req=%b we=%b a=%h wd=%h m=%h want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_wmask);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        total++;
        if (cpu_req_ready !== 1'b1 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b req=%b want 1 0",
                     cpu_req_ready, mem_req);
        end
    endtask

    task automatic test_amo_add();
        logic [31:0] rd, erd;
        int lat, elat;
        exec(OP_STORE, 32'h8000_1000, 32'd30, 4'hF, rd, lat, erd, elat);
        total++;
        if (rd !== 32'd0 || lat != 3) begin
            bad++;
            $display("FAIL store_lat: got rd=%h lat=%0d want 0 3", rd, lat);
        end
        exec(OP_ADD, 32'h8000_1000, 32'd60, 4'h0, rd, lat, erd, elat);
        total++;
        if (rd !== 32'd30 || lat != 5) begin
            bad++;
            $display("FAIL amoadd: got rd=%0d lat=%0d want 30 5", rd, lat);
        end
        exec(OP_LOAD, 32'h8000_1000, 32'd0, 4'h0, rd, lat, erd, elat);
        total++;
        if (rd !== 32'd90 || lat != 4) begin
            bad++;
            $display("FAIL amoadd_load: got rd=%0d lat=%0d want 90 4", rd, lat);
        end
    endtask

    task automatic test_lr_sc();
        logic [31:0] rd, erd;
        int lat, elat;
        exec(OP_STORE, 32'h8000_1000, 32'd30, 4'hF, rd, lat, erd, elat);
        exec(OP_LR, 32'h8000_1000, 32'd0, 4'h0, rd, lat, erd, elat);
        total++;
        if (rd !== 32'd30 || lat != 4) begin
            bad++;
            $display("FAIL lr: got rd=%0d lat=%0d want 30 4", rd, lat);
        end
        exec(OP_SC, 32'h8000_1000, 32'h55, 4'h0, rd, lat, erd, elat);
        total++;
        if (rd !== 32'd0 || lat != 5) begin
            bad++;
            $display("FAIL sc_ok: got rd=%0d lat=%0d want 0 5", rd, lat);
        end
        exec(OP_LOAD, 32'h8000_1000, 32'd0, 4'h0, rd, lat, erd, elat);
        total++;
        if (rd !== 32'h55) begin
            bad++;
            $display("FAIL sc_load: got %h want 55", rd);
        end
    endtask

    task automatic test_sc_fail();
        logic [31:0] rd, erd;
        int lat, elat, r0;
        r0 = req_cnt;
        exec(OP_SC, 32'h8000_2000, 32'h77, 4'h0, rd, lat, erd, elat);
        total++;
        if (rd !== 32'd1 || lat != 2) begin
            bad++;
            $display("FAIL sc_fail: got rd=%0d lat=%0d want 1 2", rd, lat);
        end
        total++;
        if (req_cnt != r0) begin
            bad++;
            $display("FAIL sc_fail_noreq: got %0d mem_req cycles want 0",
                     req_cnt - r0);
        end
        total++;
        if (ram_word(widx(32'h8000_2000)) !== init_word(widx(32'h8000_2000))) begin
            bad++;
            $display("FAIL sc_fail_mem: got %h want %h",
                     ram_word(widx(32'h8000_2000)), init_word(widx(32'h8000_2000)));
        end
    endtask

    task automatic test_store_kill();
        logic [31:0] rd, erd;
        int lat, elat;
        exec(OP_LR, 32'h8000_1040, 32'd0, 4'h0, rd, lat, erd, elat);
        exec(OP_STORE, 32'h8000_1040, 32'hCAFE_F00D, 4'hF, rd, lat, erd, elat);
        exec(OP_SC, 32'h8000_1040, 32'h1111, 4'h0, rd, lat, erd, elat);
        total++;
        if (rd !== 32'd1 || lat != 2) begin
            bad++;
            $display("FAIL store_kill_sc: got rd=%0d lat=%0d want 1 2", rd, lat);
        end
        total++;
        if (ram_word(widx(32'h8000_1040)) !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL store_kill_mem: got %h want cafef00d",
                     ram_word(widx(32'h8000_1040)));
        end
    endtask

    task automatic test_min();
        logic [31:0] rd, erd;
        int lat, elat;
        exec(OP_STORE, 32'h8000_1080, 32'hFFFF_FFFF, 4'hF, rd, lat, erd, elat);
        exec(OP_MIN, 32'h8000_1080, 32'd1, 4'h0, rd, lat, erd, elat);
        total++;
        if (rd !== 32'hFFFF_FFFF || ram_word(widx(32'h8000_1080)) !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL amomin: got rd=%h mem=%h want ffffffff ffffffff",
                     rd, ram_word(widx(32'h8000_1080)));
        end
        exec(OP_STORE, 32'h8000_1080, 32'hFFFF_FFFF, 4'hF, rd, lat, erd, elat);
        exec(OP_MINU, 32'h8000_1080, 32'd1, 4'h0, rd, lat, erd, elat);
        total++;
        if (rd !== 32'hFFFF_FFFF || ram_word(widx(32'h8000_1080)) !== 32'd1) begin
            bad++;
            $display("FAIL amominu: got rd=%h mem=%h want ffffffff 1",
                     rd, ram_word(widx(32'h8000_1080)));
        end
    endtask

    task automatic test_stall_reset();
        logic [31:0] rd, erd;
        int lat, elat, n, j;
        j = widx(32'h8000_10C0);
        exec(OP_STORE, 32'h8000_10C0, 32'd5, 4'hF, rd, lat, erd, elat);
        hold_wr = 1'b1;
        @(negedge CLK);
        n = 0;
        while (!cpu_req_ready && n < 50) begin @(negedge CLK); n++; end
        cpu_req_valid = 1'b1;
        cpu_op = OP_ADD; cpu_addr = 32'h8000_10C0;
        cpu_wdata = 32'd7; cpu_wstrb = 4'h0;
        @(posedge CLK); #1;
        cpu_req_valid = 1'b0;
        n = 0;
        while (!mem_we && n < 20) begin @(negedge CLK); n++; end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL stall_reach_wr: got no write in %0d cycles want write", n);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            total++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h10C ||
                mem_wmask !== 16'h000F || mem_wdata !== 128'd12 ||
                cpu_resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: got req=%b we=%b a=%h m=%h wd=%h rv=%b want 1 1 10c 000f 12 0",
                         k, mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
                         cpu_resp_valid);
            end
        end
        @(negedge CLK);
        RST_N = 1'b0;
        hold_wr = 1'b0;
        rv = 1'b0;
        #1;
        total++;
        if ({cpu_req_ready, cpu_resp_valid, cpu_rdata} !== {1'b1, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL midreset_cpu: got %b %b %h want 1 0 0",
                     cpu_req_ready, cpu_resp_valid, cpu_rdata);
        end
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== '0) begin
            bad++;
            $display("FAIL midreset_mem: got req=%b we=%b a=%h wd=%h m=%h want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_wmask);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        total++;
        if (ram_word(j) !== 32'd5) begin
            bad++;
            $display("FAIL midreset_nowrite: got %h want 5", ram_word(j));
        end
        exec(OP_ADD, 32'h8000_10C0, 32'd7, 4'h0, rd, lat, erd, elat);
        total++;
        if (rd !== 32'd5 || lat != 5 || ram_word(j) !== 32'd12) begin
            bad++;
            $display("FAIL after_reset_amo: got rd=%0d lat=%0d mem=%0d want 5 5 12",
                     rd, lat, ram_word(j));
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd;
        logic [3:0] op, st;
        int lat, elat, j;
        rand_stall = 1'b1;
        for (int it = 0; it < 300; it++) begin
            a = BASE + 32'h1000 + (32'($urandom_range(0, 3)) << 4)
                + (32'($urandom_range(0, 1)) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'h0001_0000;
            op = 4'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) op = OP_SC;
            if ($urandom_range(0, 4) == 0) op = OP_LR;
            wd = $urandom;
            if ($urandom_range(0, 1) == 0) wd = 32'($urandom_range(0, 3)) - 32'd1;
            st = 4'($urandom_range(0, 15));
            exec(op, a, wd, st, rd, lat, erd, elat);
            j = widx(a);
            total++;
            if (rd !== erd) begin
                bad++;
                $display("FAIL rnd_rdata[%0d] op=%0d a=%h: got %h want %h",
                         it, op, a, rd, erd);
            end
            total++;
            if (lat != elat) begin
                bad++;
                $display("FAIL rnd_lat[%0d] op=%0d: got %0d want %0d",
                         it, op, lat, elat);
            end
            total++;
            if (ram_word(j) !== mw[j]) begin
                bad++;
                $display("FAIL rnd_mem[%0d] op=%0d a=%h: got %h want %h",
                         it, op, a, ram_word(j), mw[j]);
            end
        end
        rand_stall = 1'b0;
    endtask

    initial begin
        for (int j = 0; j < 16384; j++) mw[j] = init_word(j);
        test_reset();
        test_amo_add();
        test_lr_sc();
        test_sc_fail();
        test_store_kill();
        test_min();
        test_stall_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
